// File: rtl/tbus_arbiter.sv
// Round-robin owner selection for a shared TINV-driven bus. It inserts a one-cycle
// all-off turnaround between owners and drives complementary EN/nEN per driver bank.
module tbus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] drv_en,
    output logic [N_REQ-1:0] drv_nen,
    output logic             bus_idle
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = IW + 1;
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] REQ_LAST  = IW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    owner, owner_next;
    logic [IW-1:0]    rr_ptr, rr_next;
    logic [IW-1:0]    winner;
    logic [HW-1:0]    hold_cnt, hold_next;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] grant_next;
    logic             release_bus;

    // First asserted request at or above ptr, wrapping from N_REQ-1 back to 0.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] pick;
        logic [PW-1:0] pos;
        logic          found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + PW'(i);
            if (pos >= PW'(N_REQ))
                pos = pos - PW'(N_REQ);
            if (!found && r[pos[IW-1:0]]) begin
                pick  = pos[IW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner   = rr_pick(req, rr_ptr);
    assign owner_oh = N_REQ'(1) << owner;

    // Owner dropping req and hold expiry fold into a single release term.
    assign release_bus = !req[owner] ||
                         ((hold_cnt == HOLD_LAST) && (|(req & ~owner_oh)));

    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        hold_next  = hold_cnt;
        case (state)
            IDLE, TURN: begin
                if (|req) begin
                    state_next = GRANT;
                    owner_next = winner;
                    hold_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (release_bus) begin
                    state_next = TURN;
                    rr_next    = (owner == REQ_LAST) ? '0 : owner + IW'(1);
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        grant_next = (state_next == GRANT) ? (N_REQ'(1) << owner_next) : '0;
    end

    // Outputs are flopped from the next-state decode so req never reaches a pin combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            drv_en   <= '0;
            drv_nen  <= '1;
            bus_idle <= 1'b1;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_next;
            hold_cnt <= hold_next;
            grant    <= grant_next;
            drv_en   <= grant_next;
            drv_nen  <= ~grant_next;
            bus_idle <= (state_next != GRANT);
        end
    end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Bench for tbus_arbiter: directed scenarios plus random request traffic, checked
// against an owner/pointer/held-count reference model of the arbitration rules.
module tb_tbus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] drv_en;
    logic [N-1:0] drv_nen;
    logic         bus_idle;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner = -1 means nobody drives the bus.
    int           m_owner = -1;
    int           m_ptr   = 0;
    int           m_held  = 0;
    logic [N-1:0] exp_g;

    always #5 clk = ~clk;

    tbus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .drv_en   (drv_en),
        .drv_nen  (drv_nen),
        .bus_idle (bus_idle)
    );

    function automatic int scan(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (((r >> ((p + i) % N)) & N'(1)) != '0)
                return (p + i) % N;
        return -1;
    endfunction

    task automatic model_step();
        bit own_req;
        bit others;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            own_req = ((req >> m_owner) & N'(1)) != '0;
            others  = (req & ~(N'(1) << m_owner)) != '0;
            if (!own_req || (m_held >= MH && others)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (req != '0) begin
            m_owner = scan(req, m_ptr);
            m_held  = 1;
        end
    endtask

    task automatic check_model();
        exp_g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        vectors++;
        assert (grant === exp_g) else begin
            miscompares++;
            $error("FAIL grant observed=%b expected=%b", grant, exp_g);
        end
        vectors++;
        assert (drv_en === exp_g) else begin
            miscompares++;
            $error("FAIL drv_en observed=%b expected=%b", drv_en, exp_g);
        end
        vectors++;
        assert (drv_nen === ~exp_g) else begin
            miscompares++;
            $error("FAIL drv_nen observed=%b expected=%b", drv_nen, ~exp_g);
        end
        vectors++;
        assert (bus_idle === (m_owner < 0)) else begin
            miscompares++;
            $error("FAIL bus_idle observed=%b expected=%b", bus_idle, (m_owner < 0));
        end
        vectors++;
        assert ($countones(drv_en) <= 1) else begin
            miscompares++;
            $error("FAIL onehot drv_en observed=%b expected=at most one bit", drv_en);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic expect_grant(input string tag, input logic [N-1:0] e);
        vectors++;
        assert (grant === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, grant, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;

        // Reset held with every requester asserting.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_grant("reset_grant", 4'b0000);
        end
        rst = 1'b0;
        tick();
        expect_grant("first_grant", 4'b0001);

        // Full contention: MH cycles each, one dead cycle between owners.
        for (int c = 0; c < MH - 1; c++) begin
            tick();
            expect_grant("rr_owner0", 4'b0001);
        end
        for (int o = 1; o <= 4; o++) begin
            tick();
            expect_grant("rr_turn", 4'b0000);
            for (int c = 0; c < MH; c++) begin
                tick();
                expect_grant("rr_owner", 4'(1 << (o % 4)));
            end
        end

        // Drain to idle.
        req = 4'b0000;
        tick();
        expect_grant("drain_turn", 4'b0000);
        tick();
        expect_grant("drain_idle", 4'b0000);

        // Single requester from idle, then drop.
        req = 4'b0100;
        tick();
        expect_grant("single_grant", 4'b0100);
        tick();
        expect_grant("single_hold", 4'b0100);
        req = 4'b0000;
        tick();
        expect_grant("single_turn", 4'b0000);
        tick();
        expect_grant("single_idle", 4'b0000);

        // Early release: owner 1 drops after two cycles, requester 3 waits, 2 idle.
        req = 4'b0010;
        tick();
        expect_grant("early_own1", 4'b0010);
        req = 4'b1010;
        tick();
        expect_grant("early_own1_b", 4'b0010);
        req = 4'b1000;
        tick();
        expect_grant("early_turn", 4'b0000);
        tick();
        expect_grant("early_next3", 4'b1000);

        // Late competitor: owner 0 alone for 10 cycles, then req2 arrives.
        req = 4'b0001;
        tick();
        expect_grant("late_turn0", 4'b0000);
        for (int c = 0; c < 10; c++) begin
            tick();
            expect_grant("late_alone0", 4'b0001);
        end
        req = 4'b0101;
        tick();
        expect_grant("late_turn", 4'b0000);
        tick();
        expect_grant("late_grant2", 4'b0100);

        // Reset in the middle of owner 2's grant.
        tick();
        expect_grant("mid_hold2", 4'b0100);
        rst = 1'b1;
        tick();
        expect_grant("mid_reset", 4'b0000);
        rst = 1'b0;
        req = 4'b0110;
        tick();
        expect_grant("post_reset", 4'b0010);
        tick();
        expect_grant("post_reset_hold", 4'b0010);

        // Random traffic with sticky requests and rare resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(5) == 0)
                    req = req ^ (N'(1) << b);
            rst = ($urandom_range(80) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
